// File: rtl/tick_timer_ctrl.sv
// tick_timer_ctrl: prescaled tick generator driving a loadable countdown.
// A 26-bit prescaler divides the clock by CLK_DIV to make ticks. Each tick
// decrements the remaining count. done pulses when the count reaches zero.
// Pause freezes the prescaler and the count. clear aborts to IDLE.
module tick_timer_ctrl #(
   parameter int unsigned CLK_DIV = 250000,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             start,
   input  logic             pause,
   input  logic [CNT_W-1:0] load_value,
   output logic             tick,
   output logic [CNT_W-1:0] remaining,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state
);

   localparam logic [25:0] PSC_MAX = 26'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      cur_state;
   state_t      nxt_state;
   logic [25:0] prescaler;
   logic        accept;
   logic        zero_load;
   logic        advance;
   logic        wrap;
   logic        last;

   // A start is honoured only from IDLE/DONE and loses to clear.
   assign accept    = start && !clear && ((cur_state == IDLE) || (cur_state == DONE));
   assign zero_load = (load_value == '0);
   // The prescaler moves only in RUN on a cycle with pause low.
   assign advance   = (cur_state == RUN) && !pause && !clear;
   assign wrap      = advance && (prescaler == PSC_MAX);
   assign last      = wrap && (remaining == CNT_W'(1));

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         cur_state <= IDLE;
      end else begin
         cur_state <= nxt_state;
      end
   end

   // Next-state selection with priority clear > start > pause.
   always_comb begin
      nxt_state = cur_state;
      if (clear) begin
         nxt_state = IDLE;
      end else begin
         case (cur_state)
            IDLE, DONE: begin
               if (start) begin
                  nxt_state = zero_load ? DONE : RUN;
               end
            end
            RUN: begin
               if (pause) begin
                  nxt_state = PAUSE;
               end else if (last) begin
                  nxt_state = DONE;
               end
            end
            PAUSE: begin
               if (!pause) begin
                  nxt_state = RUN;
               end
            end
            default: nxt_state = IDLE;
         endcase
      end
   end

   // Prescaler, countdown and the registered tick/done pulses.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         prescaler <= '0;
         remaining <= '0;
         tick      <= 1'b0;
         done      <= 1'b0;
      end else begin
         tick <= wrap;
         done <= last || (accept && zero_load);
         if (accept) begin
            prescaler <= '0;
            remaining <= load_value;
         end else if (advance) begin
            if (wrap) begin
               prescaler <= '0;
               remaining <= remaining - CNT_W'(1);
            end else begin
               prescaler <= prescaler + 26'd1;
            end
         end
      end
   end

   // Status outputs decoded from the current state.
   always_comb begin
      busy  = (cur_state == RUN) || (cur_state == PAUSE);
      state = cur_state;
   end

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// Directed bench for tick_timer_ctrl with CLK_DIV=4, CNT_W=8.
// Inputs change 1 time unit after a rising edge; outputs are read there too,
// so cycle k below means "just after the k-th edge following the start-accept edge".
module tb_tick_timer_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       clear = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [7:0] load_value = '0;
   logic       tick;
   logic [7:0] remaining;
   logic       busy;
   logic       done;
   logic [1:0] state;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   tick_timer_ctrl #(
      .CLK_DIV (4),
      .CNT_W   (8)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .clear      (clear),
      .start      (start),
      .pause      (pause),
      .load_value (load_value),
      .tick       (tick),
      .remaining  (remaining),
      .busy       (busy),
      .done       (done),
      .state      (state)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // One-cycle start pulse; returns just after the accept edge (cycle 0).
   task automatic launch(input logic [7:0] v);
      load_value = v;
      start      = 1'b1;
      step();
      start      = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_state"}, state, 0);
      check({tag, "_rem"}, remaining, 0);
      check({tag, "_tick"}, tick, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      // Reset state.
      step();
      step();
      reset = 1'b0;
      check_idle("reset");

      // Basic countdown: 3 ticks at +4, +8, +12.
      launch(8'd3);
      check("basic_k0_state", state, 1);
      check("basic_k0_rem", remaining, 3);
      check("basic_k0_busy", busy, 1);
      for (int k = 1; k <= 12; k++) begin
         step();
         check($sformatf("basic_k%0d_tick", k), tick, (k % 4 == 0));
         check($sformatf("basic_k%0d_done", k), done, (k == 12));
         check($sformatf("basic_k%0d_rem", k), remaining, 3 - k / 4);
      end
      check("basic_k12_state", state, 3);
      check("basic_k12_busy", busy, 0);
      step();
      check("basic_hold_state", state, 3);
      check("basic_hold_done", done, 0);
      check("basic_hold_rem", remaining, 0);

      // Zero load from DONE: immediate done, no tick.
      launch(8'd0);
      check("zero_state", state, 3);
      check("zero_done", done, 1);
      check("zero_tick", tick, 0);
      check("zero_rem", remaining, 0);
      step();
      check("zero_done_end", done, 0);
      check("zero_tick_end", tick, 0);
      check("zero_state_end", state, 3);

      // Pause: sampled high on edges 3..6, so the edge back to RUN adds a
      // fifth stalled cycle; ticks land at +9 and +13.
      launch(8'd2);
      step();
      step();
      pause = 1'b1;
      for (int k = 3; k <= 6; k++) begin
         step();
         check($sformatf("pause_k%0d_state", k), state, 2);
         check($sformatf("pause_k%0d_tick", k), tick, 0);
         check($sformatf("pause_k%0d_rem", k), remaining, 2);
         check($sformatf("pause_k%0d_busy", k), busy, 1);
      end
      pause = 1'b0;
      for (int k = 7; k <= 13; k++) begin
         step();
         check($sformatf("pause_k%0d_tick", k), tick, (k == 9 || k == 13));
         check($sformatf("pause_k%0d_done", k), done, (k == 13));
         check($sformatf("pause_k%0d_rem", k), remaining, (k < 9) ? 2 : ((k < 13) ? 1 : 0));
         check($sformatf("pause_k%0d_state", k), state, (k == 13) ? 3 : 1);
      end

      // Pause exactly when the prescaler sits at CLK_DIV-1: no tick that cycle.
      launch(8'd1);
      step();
      step();
      step();
      pause = 1'b1;
      step();
      check("pmax_tick", tick, 0);
      check("pmax_state", state, 2);
      check("pmax_rem", remaining, 1);
      check("pmax_done", done, 0);
      pause = 1'b0;
      step();
      check("pmax_resume_state", state, 1);
      check("pmax_resume_tick", tick, 0);
      step();
      check("pmax_tick_after", tick, 1);
      check("pmax_done_after", done, 1);
      check("pmax_state_after", state, 3);

      // Restart attempt while running is ignored.
      launch(8'd2);
      step();
      step();
      load_value = 8'd9;
      start      = 1'b1;
      step();
      start      = 1'b0;
      check("restart_rem", remaining, 2);
      check("restart_state", state, 1);
      for (int k = 4; k <= 8; k++) begin
         step();
         check($sformatf("restart_k%0d_tick", k), tick, (k == 4 || k == 8));
         check($sformatf("restart_k%0d_rem", k), remaining, (k < 8) ? 1 : 0);
         check($sformatf("restart_k%0d_done", k), done, (k == 8));
      end
      check("restart_end_state", state, 3);

      // Clear at +6 of a 3-tick countdown.
      launch(8'd3);
      for (int k = 1; k <= 5; k++) step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      check_idle("clear");
      for (int k = 0; k < 8; k++) begin
         step();
         check($sformatf("clear_quiet%0d_tick", k), tick, 0);
         check($sformatf("clear_quiet%0d_done", k), done, 0);
         check($sformatf("clear_quiet%0d_state", k), state, 0);
      end

      // start and clear together in DONE resolve to IDLE.
      launch(8'd1);
      for (int k = 1; k <= 4; k++) step();
      check("sc_pre_state", state, 3);
      check("sc_pre_done", done, 1);
      step();
      load_value = 8'd5;
      start      = 1'b1;
      clear      = 1'b1;
      step();
      start      = 1'b0;
      clear      = 1'b0;
      check_idle("start_clear");

      // Reset at +5 aborts without done; next start runs normally.
      launch(8'd3);
      for (int k = 1; k <= 4; k++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_idle("midreset");
      launch(8'd1);
      check("post_reset_state", state, 1);
      check("post_reset_rem", remaining, 1);
      for (int k = 1; k <= 4; k++) begin
         step();
         check($sformatf("post_reset_k%0d_done", k), done, (k == 4));
         check($sformatf("post_reset_k%0d_tick", k), tick, (k == 4));
      end
      check("post_reset_end_state", state, 3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
